// File: rtl/ldm_writeback_seq_pkg.sv
// Shared types and helpers for the LDM write-back sequencer.
// State encoding, word/PC constants and a register-list popcount.
package ldm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ldm_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned PC_INDEX   = 15;
    localparam int unsigned LIST_MAX   = 32;

    function automatic logic [5:0] popcount(input logic [LIST_MAX-1:0] v);
        logic [5:0]          n;
        logic [LIST_MAX-1:0] s;
        n = '0;
        s = v;
        for (int unsigned i = 0; i < LIST_MAX; i++) begin
            n = n + {5'b0, s[0]};
            s = s >> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/ldm_writeback_seq_reg_list_encoder.sv
// Lowest-set-bit priority encoder over a register list.
// Reports the index of the lowest listed register and whether any bit is set.
module reg_list_encoder
    import ldm_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic [NUM_REGS-1:0]   list,
    output logic [ADDR_WIDTH-1:0] index,
    output logic                  valid
);

    logic [NUM_REGS-1:0] scan;

    // Shift-and-test keeps the scan free of variable bit selects.
    always_comb begin
        index = '0;
        valid = 1'b0;
        scan  = list;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (scan[0] && !valid) begin
                index = ADDR_WIDTH'(i);
                valid = 1'b1;
            end
            scan = scan >> 1;
        end
    end

endmodule

// File: rtl/ldm_writeback_seq.sv
// LDM write-back sequencer: walks a register list, fetches one word per register
// and writes it to the register file. Optional PC path: define LDM_PC_WRITE_EN.
module ldm_writeback_seq
    import ldm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [NUM_REGS-1:0]   REGLIST,
    input  logic [DATA_WIDTH-1:0] BASE,
    input  logic                  UP,
    input  logic [DATA_WIDTH-1:0] MDATA,
    input  logic                  MVALID,
    output logic                  MREQ,
    output logic [DATA_WIDTH-1:0] MADDR,
    output logic [ADDR_WIDTH-1:0] RW,
    output logic [DATA_WIDTH-1:0] PW,
    output logic                  LE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] WBADDR
`ifdef LDM_PC_WRITE_EN
    ,
    output logic                  PC_LOAD,
    output logic [DATA_WIDTH-1:0] PC_VALUE
`endif
);

    localparam logic [NUM_REGS-1:0] PC_MASK =
        (NUM_REGS > PC_INDEX) ? (NUM_REGS'(1) << PC_INDEX) : '0;
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(WORD_BYTES);

    ldm_state_t state, state_nxt;

    logic [NUM_REGS-1:0]   remain, remain_nxt, remain_clr;
    logic [NUM_REGS-1:0]   eff_list;
    logic [5:0]            cnt;
    logic [DATA_WIDTH-1:0] span, start_addr, wb_calc, next_addr;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_valid;

    logic                  mreq_nxt, le_nxt, busy_nxt, done_nxt;
    logic [DATA_WIDTH-1:0] maddr_nxt, pw_nxt, wbaddr_nxt;
    logic [ADDR_WIDTH-1:0] rw_nxt;
`ifdef LDM_PC_WRITE_EN
    logic                  pc_load_nxt;
    logic [DATA_WIDTH-1:0] pc_value_nxt;
`endif

`ifdef LDM_PC_WRITE_EN
    assign eff_list = REGLIST;
`else
    assign eff_list = REGLIST & ~PC_MASK;
`endif

    assign cnt        = popcount(LIST_MAX'(eff_list));
    assign span       = DATA_WIDTH'(cnt) * STEP;
    // Decrement-after walks upward from the lowest address of the block.
    assign start_addr = UP ? BASE : (BASE - span + STEP);
    assign wb_calc    = UP ? (BASE + span) : (BASE - span);
    assign next_addr  = MADDR + STEP;
    assign remain_clr = remain & (remain - NUM_REGS'(1));

    reg_list_encoder #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_enc (
        .list  (remain),
        .index (cur_idx),
        .valid (cur_valid)
    );

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        mreq_nxt   = 1'b0;
        maddr_nxt  = MADDR;
        rw_nxt     = RW;
        pw_nxt     = PW;
        le_nxt     = 1'b0;
        busy_nxt   = BUSY;
        done_nxt   = 1'b0;
        wbaddr_nxt = WBADDR;
`ifdef LDM_PC_WRITE_EN
        pc_load_nxt  = 1'b0;
        pc_value_nxt = PC_VALUE;
`endif
        unique case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (START) begin
                    wbaddr_nxt = wb_calc;
                    remain_nxt = eff_list;
                    if (cnt != '0) begin
                        state_nxt = REQ;
                        busy_nxt  = 1'b1;
                        mreq_nxt  = 1'b1;
                        maddr_nxt = start_addr;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (MVALID && cur_valid) begin
                    remain_nxt = remain_clr;
                    rw_nxt     = cur_idx;
                    pw_nxt     = MDATA;
                    le_nxt     = 1'b1;
`ifdef LDM_PC_WRITE_EN
                    if (cur_idx == ADDR_WIDTH'(PC_INDEX)) begin
                        rw_nxt       = RW;
                        pw_nxt       = PW;
                        le_nxt       = 1'b0;
                        pc_load_nxt  = 1'b1;
                        pc_value_nxt = {MDATA[DATA_WIDTH-1:2], 2'b00};
                    end
`endif
                    // Next request overlaps the current write-back.
                    if (remain_clr != '0) begin
                        state_nxt = REQ;
                        mreq_nxt  = 1'b1;
                        maddr_nxt = next_addr;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            remain <= '0;
            MREQ   <= 1'b0;
            MADDR  <= '0;
            RW     <= '0;
            PW     <= '0;
            LE     <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            WBADDR <= '0;
`ifdef LDM_PC_WRITE_EN
            PC_LOAD  <= 1'b0;
            PC_VALUE <= '0;
`endif
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
            MREQ   <= mreq_nxt;
            MADDR  <= maddr_nxt;
            RW     <= rw_nxt;
            PW     <= pw_nxt;
            LE     <= le_nxt;
            BUSY   <= busy_nxt;
            DONE   <= done_nxt;
            WBADDR <= wbaddr_nxt;
`ifdef LDM_PC_WRITE_EN
            PC_LOAD  <= pc_load_nxt;
            PC_VALUE <= pc_value_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ldm_writeback_seq.sv
// Self-checking bench for ldm_writeback_seq: table-driven transfers plus
// hand-written latency, reset and R15 sequences, with a write scoreboard.
module tb_ldm_writeback_seq;

    typedef struct packed {
        logic        is_pc;
        logic [3:0]  rw;
        logic [31:0] pw;
    } wr_t;

    typedef struct {
        logic [15:0] rl;
        logic [31:0] base;
        logic        up;
        logic [31:0] wb;
        int          edges;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST, START, UP, MVALID;
    logic [15:0] REGLIST;
    logic [31:0] BASE, MDATA;
    logic        MREQ, LE, BUSY, DONE;
    logic [31:0] MADDR, PW, WBADDR;
    logic [3:0]  RW;
    logic        pc_load_w;
    logic [31:0] pc_value_w;

    logic        mv_auto, mv_spur, kill, fixed_en;
    logic [31:0] fixed_val;
    wr_t         wr_q[$];
    logic [31:0] addr_q[$];
    int          lat_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          le_cnt = 0;
    string       cur_test = "init";

    always #5 CLK = ~CLK;

    assign MVALID = mv_auto | mv_spur;

    ldm_writeback_seq #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .REGLIST(REGLIST), .BASE(BASE), .UP(UP),
        .MDATA(MDATA), .MVALID(MVALID), .MREQ(MREQ), .MADDR(MADDR), .RW(RW), .PW(PW),
        .LE(LE), .BUSY(BUSY), .DONE(DONE), .WBADDR(WBADDR)
`ifdef LDM_PC_WRITE_EN
        , .PC_LOAD(pc_load_w), .PC_VALUE(pc_value_w)
`endif
    );

`ifndef LDM_PC_WRITE_EN
    assign pc_load_w  = 1'b0;
    assign pc_value_w = '0;
`endif

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_test, nm, act, exp);
        end
    endtask

    // Memory responder: one response per request after a queued latency.
    initial begin
        int          pend;
        logic [31:0] pend_addr;
        mv_auto = 1'b0; MDATA = '0; pend = 0; pend_addr = '0;
        forever begin
            @(posedge CLK); #1;
            mv_auto = 1'b0;
            if (kill) pend = 0;
            else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mv_auto = 1'b1;
                    MDATA   = fixed_en ? fixed_val : pend_addr + 32'h1000;
                end
            end
            if (MREQ && !kill) begin
                pend      = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                pend_addr = MADDR;
            end
        end
    end

    // Output monitor / scoreboard.
    initial begin
        logic fire_prev, le_prev, got;
        wr_t  e;
        fire_prev = 1'b0; le_prev = 1'b0;
        forever begin
            @(negedge CLK);
            got = LE | pc_load_w;
            if (fire_prev || got) chk("write_after_mvalid", got, fire_prev);
            if (LE) begin
                le_cnt++;
                chk("le_gap", le_prev, 1'b0);
            end
            if (got) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL %s/unexpected_write: got RW=%0h PW=%0h expected none", cur_test, RW, PW);
                end else begin
                    e = wr_q.pop_front();
                    if (pc_load_w)
                        chk("pc_write", {LE, 1'b1, pc_value_w}, {1'b0, e.is_pc, e.pw & 32'hFFFF_FFFC});
                    else
                        chk("reg_write", {1'b0, RW, PW}, {e.is_pc, e.rw, e.pw});
                end
            end
            if (MREQ) begin
                if (addr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL %s/unexpected_mreq: got MADDR=%0h expected none", cur_test, MADDR);
                end else chk("maddr", MADDR, addr_q.pop_front());
            end
            fire_prev = mv_auto;
            le_prev   = LE;
        end
    end

    // Model one transfer, drive it, and wait (bounded) for DONE.
    task automatic run_xfer(input logic [15:0] rl, input logic [31:0] base, input logic up,
                            input logic [31:0] exp_wb, input int exp_edges,
                            input bit poke, input bit chain);
        logic [15:0] eff;
        logic [31:0] a;
        int          n, edges;
        bit          got_done;
        eff = rl;
`ifndef LDM_PC_WRITE_EN
        eff[15] = 1'b0;
`endif
        n = 0;
        for (int i = 0; i < 16; i++) if (eff[i]) n++;
        a = up ? base : base - 32'(4 * n) + 32'd4;
        for (int i = 0; i < 16; i++) begin
            if (eff[i]) begin
                addr_q.push_back(a);
                wr_q.push_back({(i == 15), 4'(i), fixed_en ? fixed_val : a + 32'h1000});
                a = a + 32'd4;
            end
        end
        REGLIST = rl; BASE = base; UP = up; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        if (poke) mv_spur = 1'b1;
        chk("start_busy_mreq", {MREQ, BUSY}, {2{n > 0}});
        edges = 0;
        got_done = DONE;
        while (!got_done && edges < 400) begin
            @(posedge CLK); #1;
            edges++;
            if (poke && edges == 1) mv_spur = 1'b0;
            if (poke && edges == 2) begin START = 1'b1; REGLIST = 16'hFFFF; end
            if (poke && edges == 3) begin START = 1'b0; REGLIST = rl; end
            got_done = DONE;
        end
        if (!got_done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s/done_timeout: got no DONE expected DONE", cur_test);
        end else begin
            chk("done_edges", edges, exp_edges);
            chk("wbaddr", WBADDR, exp_wb);
            chk("busy_end", BUSY, 1'b0);
        end
        if (!chain) begin
            @(posedge CLK); #1;
            chk("done_pulse", DONE, 1'b0);
            chk("queues_empty", {addr_q.size(), wr_q.size()}, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int   le_base, waited;

        tbl[0] = '{16'h0015, 32'h0000_0100, 1'b1, 32'h0000_010C, 6};
        tbl[1] = '{16'h0006, 32'h0000_0200, 1'b0, 32'h0000_01F8, 4};
        tbl[2] = '{16'h0000, 32'h0000_0300, 1'b1, 32'h0000_0300, 0};
        tbl[3] = '{16'h0000, 32'h0000_0300, 1'b0, 32'h0000_0300, 0};
        tbl[4] = '{16'h7FFF, 32'h0000_1000, 1'b1, 32'h0000_103C, 30};
        tbl[5] = '{16'h0001, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 2};
        tbl[6] = '{16'h4000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 2};
        tbl[7] = '{16'h5A5A, 32'h0000_2000, 1'b0, 32'h0000_1FE0, 16};
`ifdef LDM_PC_WRITE_EN
        tbl[8] = '{16'hFFFF, 32'h0000_0000, 1'b1, 32'h0000_0040, 32};
`else
        tbl[8] = '{16'hFFFF, 32'h0000_0000, 1'b1, 32'h0000_003C, 30};
`endif

        RST = 1'b1; START = 1'b0; REGLIST = '0; BASE = '0; UP = 1'b0;
        mv_spur = 1'b0; kill = 1'b0; fixed_en = 1'b0; fixed_val = '0;
        @(posedge CLK); @(posedge CLK); #1;
        cur_test = "reset";
        chk("rst_outs", {MREQ, MADDR, RW, PW, LE, BUSY, DONE, WBADDR}, '0);
`ifdef LDM_PC_WRITE_EN
        chk("rst_pc", {pc_load_w, pc_value_w}, '0);
`endif
        RST = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 9; i++) begin
            cur_test = $sformatf("vec%0d", i);
            run_xfer(tbl[i].rl, tbl[i].base, tbl[i].up, tbl[i].wb, tbl[i].edges, 1'b0, 1'b0);
        end

        // Spurious MVALID while idle must not write anything.
        cur_test = "spur_idle";
        le_base = le_cnt;
        mv_spur = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        mv_spur = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        chk("no_le_idle", le_cnt - le_base, 0);

        // Latencies 3/1/5, spurious MVALID in REQ, START while busy.
        cur_test = "var_lat";
        lat_q.push_back(3); lat_q.push_back(1); lat_q.push_back(5);
        run_xfer(16'h0092, 32'h0000_0040, 1'b1, 32'h0000_004C, 12, 1'b1, 1'b0);

        // New START accepted in the DONE cycle.
        cur_test = "chain_a";
        run_xfer(16'h0003, 32'h0000_0500, 1'b1, 32'h0000_0508, 4, 1'b0, 1'b1);
        cur_test = "chain_b";
        run_xfer(16'h0808, 32'h0000_0600, 1'b0, 32'h0000_05F8, 4, 1'b0, 1'b0);

        // Reset during the second WAIT.
        cur_test = "reset_mid";
        lat_q.push_back(1); lat_q.push_back(6);
        addr_q.push_back(32'h0000_0400); addr_q.push_back(32'h0000_0404);
        wr_q.push_back({1'b0, 4'd0, 32'h0000_1400});
        REGLIST = 16'h000F; BASE = 32'h0000_0400; UP = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        waited = 0;
        while (!LE && waited < 50) begin @(posedge CLK); #1; waited++; end
        chk("first_le_seen", LE, 1'b1);
        @(posedge CLK); #1;
        chk("second_wait", {BUSY, MREQ, LE}, 3'b100);
        RST = 1'b1; kill = 1'b1;
        @(posedge CLK); #1;
        chk("rst_outs", {MREQ, MADDR, RW, PW, LE, BUSY, DONE, WBADDR}, '0);
        RST = 1'b0;
        le_base = le_cnt;
        mv_spur = 1'b1;
        @(posedge CLK); #1;
        mv_spur = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        chk("late_mvalid_no_le", le_cnt - le_base, 0);
        chk("rst_queues", {addr_q.size(), wr_q.size()}, 0);
        kill = 1'b0;
        cur_test = "after_reset";
        run_xfer(16'h0015, 32'h0000_0100, 1'b1, 32'h0000_010C, 6, 1'b0, 1'b0);

        // R15 in the list.
        cur_test = "r15";
        fixed_en = 1'b1; fixed_val = 32'h0001_2347;
`ifdef LDM_PC_WRITE_EN
        run_xfer(16'h8001, 32'h0000_0000, 1'b1, 32'h0000_0008, 4, 1'b0, 1'b0);
`else
        run_xfer(16'h8001, 32'h0000_0000, 1'b1, 32'h0000_0004, 2, 1'b0, 1'b0);
`endif
        fixed_en = 1'b0;

        repeat (2) begin @(posedge CLK); #1; end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
